maxpool_kxk_stream: RTL and testbench
=====================================

Name: maxpool_kxk_stream

Overview:
- Parametrised streaming max-pool stage for the CNN layer pipeline; next generation of the fixed 3x3/stride-2 pool embedded in the layer-1 conv block.
- Accepts one raster-ordered pixel per valid cycle, all channels in parallel.
- Buffers K-1 rows per channel, forms a KxK window and emits the signed maximum per channel at the configured stride, with optional ReLU.
- Marks the last output of each frame.

Parameters:
- IMG_Width, 14, input frame width in pixels (>= Kernel)
- IMG_Height, 14, input frame height in pixels (>= Kernel)
- Datawidth, 32, bits per channel sample, two's-complement signed
- Channel, 4, parallel channels (1..16)
- Kernel, 3, pooling window size; legal values 2 or 3
- Stride, 2, window step in both directions (1..Kernel)
- ReLU, 0, 1 = clamp negative results to 0 after the max

Ports:
- clk, in, 1, clock; all logic rising-edge
- rst, in, 1, synchronous active-high reset
- valid_in, in, 1, data_in holds a valid pixel this cycle
- data_in, in, Channel*Datawidth, channel c in bits [c*Datawidth +: Datawidth]
- valid_out, out, 1, data_out valid for exactly this cycle
- data_out, out, Channel*Datawidth, per-channel pooled result; same packing as data_in
- last_out, out, 1, high with valid_out on the final output of a frame

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: valid_out=0, data_out=0, last_out=0.
  - Row/column counters and stride-phase counters are cleared to 0.
  - Line-buffer contents are don't-care; they are never output before being refilled.
- Input accept:
  - A pixel is accepted on any cycle with valid_in=1. No backpressure.
  - Gaps (valid_in=0) freeze all state; output timing is counted in accepted pixels, not cycles.
- Counters:
  - col increments 0..IMG_Width-1 per accepted pixel; at wrap, row increments.
  - After pixel (IMG_Height-1, IMG_Width-1), both counters return to 0 and the next accepted pixel starts a new frame. No idle cycle is required between frames.
- Line buffers: Kernel-1 rows x IMG_Width entries per channel, written at col.
- Window: KxK shift registers per channel, fed by the current pixel plus the line-buffer outputs at col.
  - Columns from the previous row's wrap must not leak into a window: emission starts only at col >= Kernel-1.
- Emission condition, evaluated on the accepted pixel at (row, col):
  - row >= Kernel-1 and col >= Kernel-1
  - (row-(Kernel-1)) mod Stride == 0 and (col-(Kernel-1)) mod Stride == 0
  - Implemented with phase counters, not dividers.
- Outputs per frame: OW*OH, where OW = (IMG_Width-Kernel)/Stride+1 and OH = (IMG_Height-Kernel)/Stride+1, using floor division. Trailing rows and columns that fit no full window are discarded (no padding).
- Latency: valid_out is asserted exactly 1 clock after the accepted pixel that completes a window. The result is registered.
- Arithmetic:
  - Signed comparison over all Kernel*Kernel samples, independently per channel.
  - Ties give the same value, so no ordering rule is needed.
  - ReLU=1: a negative max becomes 0. ReLU=0: the max passes unchanged. Output width equals Datawidth; no growth.
- last_out is asserted with valid_out only for the window completed by pixel (IMG_Height-1 - r0, IMG_Width-1 - c0), i.e. the final emitted window of the frame.
- Reset mid-frame: the next accepted pixel is treated as (0,0) of a fresh frame. No output may be produced from pre-reset data. An output pending in the same cycle as rst is dropped.
- valid_in during rst is ignored.

Test Plan:
- Ramp: IMG_Width=IMG_Height=6, Kernel=3, Stride=2, Channel=4, all lanes = pixel index 1..36 back-to-back -> exactly 4 outputs: 15, 17, 27, 29 on all lanes.
  - Each output arrives 1 cycle after pixel 15/17/27/29 is accepted.
  - last_out is set only with 29.
- Signed/ReLU: 6x6, K=3, S=2, all lanes = -(index) -> outputs -1, -3, -13, -15 with ReLU=0; all outputs 0 with ReLU=1.
  - Lane 0 = +index while other lanes are negative -> lanes stay independent.
- Gaps: the ramp stimulus with valid_in deasserted 1-3 random cycles between pixels -> identical output values and count. Each valid_out still occurs 1 cycle after its completing pixel.
- Geometry sweep: K=2, S=2, 7x7 ramp -> 9 outputs (OW=OH=3), values 9, 11, 13, 23, 25, 27, 37, 39, 41; trailing row and column discarded.
  - K=3, S=1, 5x5 ramp -> 9 outputs, 13..25 excluding row edges: 13, 14, 15, 18, 19, 20, 23, 24, 25.
- Frame continuity and reset: two 6x6 ramp frames back-to-back -> 8 outputs, with last_out on the 4th and 8th.
  - rst pulsed after pixel 20 of a frame, then a fresh frame -> no output before the new frame's pixel 15; then exactly 15, 17, 27, 29.

Source files
------------

// File: rtl/maxpool_kxk_stream.sv
// Streaming KxK signed max-pool over raster-ordered pixels, all channels in parallel.
// Keeps Kernel-1 line buffers plus Kernel-1 stored window columns per channel; emits at the stride.
module maxpool_kxk_stream #(
    parameter int IMG_Width  = 14,
    parameter int IMG_Height = 14,
    parameter int Datawidth  = 32,
    parameter int Channel    = 4,
    parameter int Kernel     = 3,
    parameter int Stride     = 2,
    parameter int ReLU       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [Channel*Datawidth-1:0] data_in,
    output logic                         valid_out,
    output logic [Channel*Datawidth-1:0] data_out,
    output logic                         last_out
);

    localparam int CW = (IMG_Width > 1) ? $clog2(IMG_Width) : 1;
    localparam int RW = (IMG_Height > 1) ? $clog2(IMG_Height) : 1;
    localparam int PW = (Stride > 1) ? $clog2(Stride) : 1;
    localparam int LR = Kernel - 1;
    localparam int R0 = (IMG_Height - Kernel) % Stride;
    localparam int C0 = (IMG_Width - Kernel) % Stride;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_Width - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_Height - 1);
    localparam logic [CW-1:0] COL_FINAL = CW'(IMG_Width - 1 - C0);
    localparam logic [RW-1:0] ROW_FINAL = RW'(IMG_Height - 1 - R0);
    localparam logic [CW-1:0] COL_START = CW'(Kernel - 1);
    localparam logic [RW-1:0] ROW_START = RW'(Kernel - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(Stride - 1);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [PW-1:0] cph_q;
    logic [PW-1:0] rph_q;

    logic [Datawidth-1:0] lb_q  [Channel][LR][IMG_Width];
    logic [Datawidth-1:0] win_q [Channel][Kernel][LR];
    logic [Datawidth-1:0] colv  [Channel][Kernel];

    logic                         accept;
    logic                         col_wrap;
    logic                         row_wrap;
    logic                         col_in;
    logic                         row_in;
    logic                         emit_d;
    logic                         last_d;
    logic [Channel*Datawidth-1:0] max_d;
    logic [Datawidth-1:0]         mx;

    assign accept   = valid_in && !rst;
    assign col_wrap = (col_q == COL_LAST);
    assign row_wrap = (row_q == ROW_LAST);
    assign col_in   = (col_q >= COL_START);
    assign row_in   = (row_q >= ROW_START);
    assign emit_d   = valid_in && col_in && row_in && (cph_q == '0) && (rph_q == '0);
    assign last_d   = emit_d && (row_q == ROW_FINAL) && (col_q == COL_FINAL);

    // Column vector at the current column: entry 0 is the incoming pixel, entry r is r rows above.
    always_comb begin
        for (int c = 0; c < Channel; c++) begin
            colv[c][0] = data_in[c*Datawidth +: Datawidth];
            for (int r = 1; r < Kernel; r++) begin
                colv[c][r] = lb_q[c][r-1][col_q];
            end
        end
    end

    always_comb begin
        max_d = '0;
        mx    = '0;
        for (int c = 0; c < Channel; c++) begin
            mx = colv[c][0];
            for (int r = 1; r < Kernel; r++) begin
                if ($signed(colv[c][r]) > $signed(mx)) mx = colv[c][r];
            end
            for (int r = 0; r < Kernel; r++) begin
                for (int j = 0; j < LR; j++) begin
                    if ($signed(win_q[c][r][j]) > $signed(mx)) mx = win_q[c][r][j];
                end
            end
            if (ReLU != 0 && mx[Datawidth-1]) mx = '0;
            max_d[c*Datawidth +: Datawidth] = mx;
        end
    end

    // Phase counters only advance once the window fits, so phase 0 marks a stride-aligned window.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            cph_q <= '0;
            rph_q <= '0;
        end else if (valid_in) begin
            col_q <= col_wrap ? '0 : col_q + 1'b1;
            if (col_wrap) begin
                cph_q <= '0;
            end else if (col_in) begin
                cph_q <= (cph_q == PH_LAST) ? '0 : cph_q + 1'b1;
            end
            if (col_wrap) begin
                row_q <= row_wrap ? '0 : row_q + 1'b1;
                if (row_wrap) begin
                    rph_q <= '0;
                end else if (row_in) begin
                    rph_q <= (rph_q == PH_LAST) ? '0 : rph_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < Channel; c++) begin
                for (int r = 0; r < LR; r++) begin
                    lb_q[c][r][col_q] <= colv[c][r];
                end
                for (int r = 0; r < Kernel; r++) begin
                    win_q[c][r][0] <= colv[c][r];
                    for (int j = 1; j < LR; j++) begin
                        win_q[c][r][j] <= win_q[c][r][j-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= emit_d;
            last_out  <= last_d;
            if (emit_d) data_out <= max_d;
        end
    end

endmodule

// File: tb/tb_maxpool_kxk_stream.sv
// Bench for maxpool_kxk_stream: four geometries, queue-based scoreboard built from a direct window model.
module tb_maxpool_kxk_stream;

    logic         clk;
    logic         rst;
    logic         vin  [4];
    logic [127:0] din  [4];
    logic         vout [4];
    logic [127:0] dout [4];
    logic         lout [4];

    logic [128:0] exp_q[$];
    logic         ev;
    logic         mon_en;
    int           act;
    int           n_cmp;
    int           n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    maxpool_kxk_stream #(.IMG_Width(6), .IMG_Height(6), .Datawidth(32), .Channel(4),
        .Kernel(3), .Stride(2), .ReLU(0)) u_k3s2 (
        .clk(clk), .rst(rst), .valid_in(vin[0]), .data_in(din[0]),
        .valid_out(vout[0]), .data_out(dout[0]), .last_out(lout[0]));

    maxpool_kxk_stream #(.IMG_Width(6), .IMG_Height(6), .Datawidth(32), .Channel(4),
        .Kernel(3), .Stride(2), .ReLU(1)) u_relu (
        .clk(clk), .rst(rst), .valid_in(vin[1]), .data_in(din[1]),
        .valid_out(vout[1]), .data_out(dout[1]), .last_out(lout[1]));

    maxpool_kxk_stream #(.IMG_Width(7), .IMG_Height(7), .Datawidth(32), .Channel(4),
        .Kernel(2), .Stride(2), .ReLU(0)) u_k2s2 (
        .clk(clk), .rst(rst), .valid_in(vin[2]), .data_in(din[2]),
        .valid_out(vout[2]), .data_out(dout[2]), .last_out(lout[2]));

    maxpool_kxk_stream #(.IMG_Width(5), .IMG_Height(5), .Datawidth(32), .Channel(4),
        .Kernel(3), .Stride(1), .ReLU(0)) u_k3s1 (
        .clk(clk), .rst(rst), .valid_in(vin[3]), .data_in(din[3]),
        .valid_out(vout[3]), .data_out(dout[3]), .last_out(lout[3]));

    task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // mode 0: ramp, 1: negated ramp, 2: lane 0 ramp with other lanes negated
    function automatic int pix_val(input int mode, input int lane, input int idx);
        if (mode == 0) return idx;
        if (mode == 1) return -idx;
        return (lane == 0) ? idx : -idx;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ev = 1'b0;
        end
    endtask

    task automatic drive_frame(input int d, input int w, input int h, input int k, input int s,
                               input int relu, input int mode, input int gaps, input int npix);
        int r, c, v, m, r0, c0;
        logic done, lst;
        logic [127:0] pk, ex;
        for (int i = 0; i < npix; i++) begin
            r = i / w;
            c = i % w;
            for (int l = 0; l < 4; l++) pk[l*32 +: 32] = pix_val(mode, l, i + 1);
            done = (r >= k - 1) && (c >= k - 1) && ((r - k + 1) % s == 0) && ((c - k + 1) % s == 0);
            lst  = done && (r == h - 1 - ((h - k) % s)) && (c == w - 1 - ((w - k) % s));
            ex   = '0;
            if (done) begin
                r0 = r - k + 1;
                c0 = c - k + 1;
                for (int l = 0; l < 4; l++) begin
                    m = pix_val(mode, l, r0 * w + c0 + 1);
                    for (int wr = 0; wr < k; wr++) begin
                        for (int wc = 0; wc < k; wc++) begin
                            v = pix_val(mode, l, (r0 + wr) * w + (c0 + wc) + 1);
                            if (v > m) m = v;
                        end
                    end
                    if (relu != 0 && m < 0) m = 0;
                    ex[l*32 +: 32] = m;
                end
            end
            vin[d] = 1'b1;
            din[d] = pk;
            @(posedge clk); #1;
            ev = done;
            if (done) exp_q.push_back({lst, ex});
            vin[d] = 1'b0;
            if (gaps != 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                    ev = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        idle(4);
        check(tag, 129'(exp_q.size()), 129'd0);
    endtask

    // Active DUT is compared against the scoreboard; the others must stay silent.
    always @(negedge clk) begin
        logic [128:0] e;
        if (mon_en) begin
            for (int d = 0; d < 4; d++) begin
                if (d == act) begin
                    if (vout[d] || ev) check("valid_out", 129'(vout[d]), 129'(ev));
                    if (vout[d]) begin
                        if (exp_q.size() == 0) begin
                            check("queue_nonempty", 129'(exp_q.size()), 129'd1);
                        end else begin
                            e = exp_q.pop_front();
                            check("data_out", 129'(dout[d]), 129'(e[127:0]));
                            check("last_out", 129'(lout[d]), 129'(e[128]));
                        end
                    end
                end else if (vout[d]) begin
                    check("idle_valid", 129'(vout[d]), 129'd0);
                end
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        ev     = 1'b0;
        act    = 0;
        rst    = 1'b1;
        for (int d = 0; d < 4; d++) begin
            vin[d] = 1'b0;
            din[d] = '1;
        end
        vin[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            check("rst_valid_out", 129'(vout[d]), 129'd0);
            check("rst_data_out", 129'(dout[d]), 129'd0);
            check("rst_last_out", 129'(lout[d]), 129'd0);
        end
        vin[0] = 1'b0;
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(2);

        act = 0; drive_frame(0, 6, 6, 3, 2, 0, 0, 0, 36); drain("ramp_drained");
        act = 0; drive_frame(0, 6, 6, 3, 2, 0, 1, 0, 36); drain("neg_drained");
        act = 1; drive_frame(1, 6, 6, 3, 2, 1, 1, 0, 36); drain("relu_drained");
        act = 0; drive_frame(0, 6, 6, 3, 2, 0, 2, 0, 36); drain("mixed_drained");
        act = 1; drive_frame(1, 6, 6, 3, 2, 1, 2, 0, 36); drain("relu_mixed_drained");
        act = 0; drive_frame(0, 6, 6, 3, 2, 0, 0, 1, 36); drain("gaps_drained");
        act = 2; drive_frame(2, 7, 7, 2, 2, 0, 0, 0, 49); drain("k2s2_drained");
        act = 3; drive_frame(3, 5, 5, 3, 1, 0, 0, 0, 25); drain("k3s1_drained");
        act = 3; drive_frame(3, 5, 5, 3, 1, 0, 1, 1, 25); drain("k3s1_neg_drained");

        act = 0;
        drive_frame(0, 6, 6, 3, 2, 0, 0, 0, 36);
        drive_frame(0, 6, 6, 3, 2, 0, 0, 0, 36);
        drain("two_frames_drained");

        act = 0;
        drive_frame(0, 6, 6, 3, 2, 0, 0, 0, 20);
        rst    = 1'b1;
        vin[0] = 1'b1;
        din[0] = '1;
        idle(2);
        rst    = 1'b0;
        vin[0] = 1'b0;
        drive_frame(0, 6, 6, 3, 2, 0, 0, 0, 36);
        drain("reset_frame_drained");

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
